// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input: a two-flop synchronizer feeds a four-state
// stability FSM that emits a registered level plus one-cycle rise/fall strobes.
module input_debouncer #(
    parameter int STABLE_COUNT = 50000,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 btn_in,
    output logic                 D,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [1:0]           dbg_state,
    output logic [CNT_WIDTH-1:0] dbg_cnt
);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_COUNT - 1);

    logic                 sync0_q, sync1_q;
    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 d_q, d_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    // Synchronizer: the only place btn_in is sampled.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
        end else begin
            sync0_q <= btn_in;
            sync1_q <= sync0_q;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LOW: begin
                cnt_d = '0;
                if (sync1_q) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!sync1_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            STABLE_HIGH: begin
                cnt_d = '0;
                if (!sync1_q) state_d = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (sync1_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
        // Level is a function of the next state so it flips on the accepting edge.
        d_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
    end

    assign D          = d_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign dbg_state  = state_q;
    assign dbg_cnt    = cnt_q;

endmodule
